// File: rtl/iz_param_serializer.sv
// Serialises one {a,b,c,d} parameter frame onto the IZ loader's 1-bit link, MSB first.
// Optional WAIT timeout with sticky error flag: define IZ_SER_TIMEOUT_EN.
module iz_param_serializer #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [DATA_W-1:0] in_c,
    input  logic [DATA_W-1:0] in_d,
    output logic              serial_data_out,
    output logic              load_enable_out,
    input  logic              params_ready_in,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [2:0]        ser_state
);

    localparam int unsigned FrameW = 4 * DATA_W;
    localparam int unsigned CntW   = $clog2(FrameW);
    localparam logic [CntW-1:0] LastBit = CntW'(FrameW - 1);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StPre   = 3'd1,
        StShift = 3'd2,
        StWait  = 3'd3,
        StDone  = 3'd4,
        StTout  = 3'd5
    } state_e;

    state_e            state_q;
    logic [FrameW-1:0] frame_q;
    logic [CntW-1:0]   bit_cnt_q;

`ifdef IZ_SER_TIMEOUT_EN
    localparam int unsigned WaitW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT_CYCLES - 1);
    logic [WaitW-1:0] wait_cnt_q;
`endif

    assign in_ready  = (state_q == StIdle) && enable;
    assign ser_state = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            frame_q         <= '0;
            bit_cnt_q       <= '0;
            serial_data_out <= 1'b0;
            load_enable_out <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
`ifdef IZ_SER_TIMEOUT_EN
            wait_cnt_q      <= '0;
`endif
        end else if (enable) begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        frame_q         <= {in_a, in_b, in_c, in_d};
                        error           <= 1'b0;
                        load_enable_out <= 1'b1;
                        serial_data_out <= 1'b0;
                        busy            <= 1'b1;
                        state_q         <= StPre;
                    end
                end
                StPre: begin
                    bit_cnt_q       <= '0;
                    serial_data_out <= frame_q[FrameW-1];
                    frame_q         <= frame_q << 1;
                    state_q         <= StShift;
                end
                StShift: begin
                    if (bit_cnt_q == LastBit) begin
                        load_enable_out <= 1'b0;
                        serial_data_out <= 1'b0;
                        state_q         <= StWait;
`ifdef IZ_SER_TIMEOUT_EN
                        wait_cnt_q      <= '0;
`endif
                    end else begin
                        bit_cnt_q       <= bit_cnt_q + 1'b1;
                        serial_data_out <= frame_q[FrameW-1];
                        frame_q         <= frame_q << 1;
                    end
                end
                StWait: begin
                    if (params_ready_in) begin
                        done    <= 1'b1;
                        state_q <= StDone;
                    end
`ifdef IZ_SER_TIMEOUT_EN
                    else if (wait_cnt_q == WaitLast) begin
                        error   <= 1'b1;
                        state_q <= StTout;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
`endif
                end
                StDone, StTout: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
